csa_stream_64b: RTL and testbench



---
 rtl/csa_stream_pkg.sv | 22 ++
 rtl/csa_stream_64b_csa.sv | 30 +++
 rtl/csa_stream_64b.sv | 124 ++++++++++++
 tb/tb_csa_stream_64b.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_stream_pkg.sv
// Shared types, state encodings and sizing helpers for the narrow-bus front/back end
// of the 64-bit carry-select adder.
package csa_stream_pkg;

  localparam int unsigned DefaultWordW = 16;

  typedef logic [1:0] state_t;

  localparam state_t LOAD_A = 2'd0;
  localparam state_t LOAD_B = 2'd1;
  localparam state_t ADD    = 2'd2;
  localparam state_t SEND   = 2'd3;

  function automatic int unsigned calc_nwords(input int unsigned word_w);
    return 64 / word_w;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned word_w);
    return (64 / word_w > 1) ? $clog2(64 / word_w) : 1;
  endfunction

endpackage

// File: rtl/csa_stream_64b_csa.sv
// 64-bit carry-select adder: four 16-bit blocks, each precomputing both carry-in cases.
module CSA_64b (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        c_out
);

  localparam int unsigned BlkW = 16;
  localparam int unsigned NBlk = 4;

  logic [NBlk:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NBlk; i++) begin : g_blk
    logic [BlkW:0] s0;
    logic [BlkW:0] s1;

    assign s0 = {1'b0, a[i*BlkW +: BlkW]} + {1'b0, b[i*BlkW +: BlkW]};
    assign s1 = {1'b0, a[i*BlkW +: BlkW]} + {1'b0, b[i*BlkW +: BlkW]} + (BlkW + 1)'(1);

    assign sum[i*BlkW +: BlkW] = carry[i] ? s1[BlkW-1:0] : s0[BlkW-1:0];
    assign carry[i+1]          = carry[i] ? s1[BlkW] : s0[BlkW];
  end

  assign c_out = carry[NBlk];

endmodule

// File: rtl/csa_stream_64b.sv
// Loads two 64-bit operands as narrow words, adds them in one CSA_64b pass and
// streams the sum back out least-significant word first.
module csa_stream_64b
  import csa_stream_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW,
  parameter int unsigned NWORDS = calc_nwords(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_cout,
  output logic              busy
);

  localparam int unsigned     IdxW    = calc_idx_w(WORD_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NWORDS - 1);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_inc;
  logic [63:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cin_q, cin_d, cout_q, cout_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [63:0]       add_sum;
  logic              add_cout;
  logic              in_fire, out_fire;

  CSA_64b u_csa (
    .a     (a_q),
    .b     (b_q),
    .cin   (cin_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == IdxLast);
  assign out_cout  = out_last & cout_q;
  assign out_data  = out_data_q;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));

  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // Counter is a power-of-two width, so the increment wraps to 0 after the last word.
  assign idx_inc = idx_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    out_data_d = out_data_q;
    case (state_q)
      LOAD_A: begin
        if (in_fire) begin
          a_d[idx_q*WORD_W +: WORD_W] = in_data;
          if (idx_q == '0) cin_d = in_cin;
          idx_d = idx_inc;
          if (idx_q == IdxLast) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_fire) begin
          b_d[idx_q*WORD_W +: WORD_W] = in_data;
          idx_d = idx_inc;
          if (idx_q == IdxLast) state_d = ADD;
        end
      end
      ADD: begin
        sum_d      = add_sum;
        cout_d     = add_cout;
        out_data_d = add_sum[WORD_W-1:0];
        idx_d      = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (out_fire) begin
          idx_d = idx_inc;
          if (idx_q == IdxLast) begin
            out_data_d = '0;
            state_d    = LOAD_A;
          end else begin
            out_data_d = sum_q[idx_inc*WORD_W +: WORD_W];
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_csa_stream_64b.sv
// Directed and lightly randomized checks of the narrow-bus adder stream wrapper.
module tb_csa_stream_64b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_cout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csa_stream_64b #(.WORD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // Drives a then b, 4 words each; in_cin is inverted on every word after the first.
  task automatic load_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input bit gaps);
    logic [63:0] src;
    for (int i = 0; i < 8; i++) begin
      src = (i < 4) ? a : b;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = src[(i % 4)*16 +: 16];
      in_cin   = (i == 0) ? cin : ~cin;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready word=%0d got=%b want=1", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    in_cin   = 1'b0;
  endtask

  // Collects 4 result words; optional stall on one word, optional random ready gaps.
  task automatic recv(output logic [63:0] s, output logic c, input int stall_word,
                      input int stall_cycles, input bit rand_ready);
    int k, guard, stalls;
    logic held, hl;
    logic [15:0] hd;
    k = 0; guard = 0; stalls = 0; held = 1'b0; hl = 1'b0; hd = '0;
    s = '0; c = 1'b0; out_ready = 1'b0;
    while (k < 4 && guard < 200) begin
      if (out_valid) begin
        if (held) begin
          total++;
          if (out_data !== hd || out_last !== hl) begin
            bad++;
            $display("FAIL hold_stable got=%h/%b want=%h/%b", out_data, out_last, hd, hl);
          end
        end
        if ((k == stall_word && stalls < stall_cycles) ||
            (rand_ready && $urandom_range(0, 3) == 0)) begin
          if (k == stall_word) stalls++;
          out_ready = 1'b0;
          held      = 1'b1;
          hd        = out_data;
          hl        = out_last;
          in_valid  = 1'b1;
          in_data   = 16'hDEAD;
          in_cin    = 1'b1;
          total++;
          if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL send_in_ready got=%b want=0", in_ready);
          end
        end else begin
          out_ready = 1'b1;
          held      = 1'b0;
          in_valid  = 1'b0;
          s[k*16 +: 16] = out_data;
          total++;
          if (out_last !== (k == 3)) begin
            bad++;
            $display("FAIL out_last word=%0d got=%b want=%b", k, out_last, (k == 3));
          end
          if (k == 3) c = out_cout;
          else begin
            total++;
            if (out_cout !== 1'b0) begin
              bad++;
              $display("FAIL out_cout_early word=%0d got=%b want=0", k, out_cout);
            end
          end
          k++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_cin    = 1'b0;
    if (k < 4) begin
      total++;
      bad++;
      $display("FAIL recv_timeout words=%0d want=4", k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data, out_last, out_cout, busy} !== {1'b1, 1'b0, 16'h0,
        1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h last=%b cout=%b busy=%b",
               in_ready, out_valid, out_data, out_last, out_cout, busy);
    end
  endtask

  task automatic test_basic();
    logic [63:0] s;
    logic c;
    load_op(64'h7FFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_cycle got vld=%b busy=%b want vld=0 busy=1", out_valid, busy);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
      bad++;
      $display("FAIL first_word_latency got vld=%b data=%h want 1/0001", out_valid, out_data);
    end
    recv(s, c, -1, 0, 1'b0);
    total++;
    if (s !== 64'h8000_0000_0000_0001 || c !== 1'b0) begin
      bad++;
      $display("FAIL basic_sum got=%h/%b want=8000000000000001/0", s, c);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL back_to_idle got vld=%b busy=%b rdy=%b", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_carry();
    logic [63:0] s;
    logic c;
    load_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    recv(s, c, -1, 0, 1'b0);
    total++;
    if (s !== 64'd0 || c !== 1'b1) begin
      bad++;
      $display("FAIL carry_sum got=%h/%b want=0000000000000000/1", s, c);
    end
  endtask

  task automatic test_cin_sampling();
    logic [63:0] s;
    logic c;
    load_op(64'd999999, 64'd111111, 1'b1, 1'b0);
    recv(s, c, -1, 0, 1'b0);
    total++;
    if (s !== 64'd1111111 || c !== 1'b0) begin
      bad++;
      $display("FAIL cin1_sum got=%0d/%b want=1111111/0", s, c);
    end
    load_op(64'd999999, 64'd111111, 1'b0, 1'b0);
    recv(s, c, -1, 0, 1'b0);
    total++;
    if (s !== 64'd1111110 || c !== 1'b0) begin
      bad++;
      $display("FAIL cin0_sum got=%0d/%b want=1111110/0", s, c);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] s;
    logic c;
    load_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
    recv(s, c, 2, 5, 1'b0);
    total++;
    if (s !== 64'h1234_5678_9ABC_DF01 || c !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_sum got=%h/%b want=123456789abcdf01/0", s, c);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [63:0] s;
    logic c;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hA5A5 ^ 16'(i);
      in_cin   = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_load_b got busy=%b rdy=%b want 1/1", busy, in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, out_data, out_last, out_cout, busy} !== {1'b1, 1'b0, 16'h0,
        1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_outputs got rdy=%b vld=%b data=%h last=%b cout=%b busy=%b",
               in_ready, out_valid, out_data, out_last, out_cout, busy);
    end
    load_op(64'd1, 64'd2, 1'b1, 1'b0);
    recv(s, c, -1, 0, 1'b0);
    total++;
    if (s !== 64'd4 || c !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_sum got=%h/%b want=0000000000000004/0", s, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, s;
    logic cin, c;
    logic [64:0] exp;
    for (int n = 0; n < 200; n++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      if (n == 0) begin a = '1; b = '1; cin = 1'b1; end
      exp = {1'b0, a} + {1'b0, b} + 65'(cin);
      load_op(a, b, cin, 1'b1);
      recv(s, c, -1, 0, 1'b1);
      total++;
      if ({c, s} !== exp) begin
        bad++;
        $display("FAIL rand_sum n=%0d got=%b/%h want=%b/%h", n, c, s, exp[64], exp[63:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_cin_sampling();
    test_backpressure();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
